// File: rtl/fact_result_buffer.sv
// rtl/fact_result_buffer.sv - first-word-fall-through result FIFO for the factorial datapath
// Optional FACT_CHECK_EN adds a sticky `mismatch` flag that checks results against a k! table.
module fact_result_buffer #(
   parameter int DATA_W = 32,
   parameter int N_W    = 5,
   parameter int DEPTH  = 4,
   parameter int MAX_N  = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_W-1:0]           in_n,
   input  logic [DATA_W-1:0]        in_result,
   input  logic                     in_ovf,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [N_W-1:0]           rd_n,
   output logic [DATA_W-1:0]        rd_result,
   output logic                     rd_ovf,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
`ifdef FACT_CHECK_EN
   output logic                     underflow,
   output logic                     mismatch
`else
   output logic                     underflow
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = DATA_W + N_W + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
   localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          underflow_q, underflow_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] head;
   logic          push, pop, full_s, empty_s;

   always_comb begin
      full_s      = (count_q == DEPTH_C);
      empty_s     = (count_q == '0);
      in_ready    = rst & ~full_s;
      push        = in_valid & in_ready;
      pop         = rd_en & ~empty_s;
      // Out-of-range n is tagged here even if the producer missed the overflow.
      wr_entry    = {in_ovf | (in_n > MAX_N_V), in_n, in_result};
      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d     = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      underflow_d = underflow_q | (rd_en & empty_s);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // Storage is never cleared, so the head is masked whenever the FIFO is empty.
   always_comb begin
      head      = mem_q[rd_ptr_q];
      rd_valid  = ~empty_s;
      rd_ovf    = empty_s ? 1'b0 : head[EW-1];
      rd_n      = empty_s ? '0 : head[DATA_W +: N_W];
      rd_result = empty_s ? '0 : head[DATA_W-1:0];
      count     = count_q;
      full      = full_s;
      empty     = empty_s;
      underflow = underflow_q;
   end

`ifdef FACT_CHECK_EN
   function automatic logic [DATA_W-1:0] fact_const(input int k);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 2; i <= k; i++) begin
         p = p * 64'(i);
      end
      return p[DATA_W-1:0];
   endfunction

   logic [DATA_W-1:0] fact_tbl [MAX_N+1];
   logic              mismatch_q, mismatch_d;
   logic              mis_hit;

   for (genvar k = 0; k <= MAX_N; k++) begin : g_tbl
      assign fact_tbl[k] = fact_const(k);
   end

   always_comb begin
      mis_hit = 1'b0;
      for (int k = 0; k <= MAX_N; k++) begin
         if (in_n == N_W'(k) && in_result != fact_tbl[k]) begin
            mis_hit = 1'b1;
         end
      end
      mismatch_d = mismatch_q | (push & mis_hit);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_fact_result_buffer.sv
// tb/tb_fact_result_buffer.sv - directed scoreboard bench for fact_result_buffer
module tb_fact_result_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_ovf, rd_en;
   logic [4:0]  in_n, rd_n;
   logic [31:0] in_result, rd_result;
   logic        rd_valid, rd_ovf, full, empty, underflow;
   logic [2:0]  count;
`ifdef FACT_CHECK_EN
   logic        mismatch;
`endif

   typedef struct packed {
      logic        ovf;
      logic [4:0]  n;
      logic [31:0] r;
   } ent_t;

   ent_t sb[$];
   int   ntests = 0;
   int   nfail  = 0;
   bit   m_under = 0;
   bit   m_mis   = 0;

   always #5 clk = ~clk;

   fact_result_buffer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n),
      .in_result(in_result), .in_ovf(in_ovf), .rd_en(rd_en), .rd_valid(rd_valid),
      .rd_n(rd_n), .rd_result(rd_result), .rd_ovf(rd_ovf), .count(count), .full(full),
      .empty(empty),
`ifdef FACT_CHECK_EN
      .underflow(underflow), .mismatch(mismatch)
`else
      .underflow(underflow)
`endif
   );

   function automatic logic [31:0] fact(input int k);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 2; i <= k; i++) p = p * 32'(i);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [4:0] n, input logic [31:0] r,
                       input logic ovf, input logic re);
      ent_t e;
      bit   acc_push, acc_pop;
      in_valid = v; in_n = n; in_result = r; in_ovf = ovf; rd_en = re;
      #1;
      chk("in_ready", in_ready, 64'(sb.size() < 4));
      if (sb.size() > 0) begin
         chk("rd_valid", rd_valid, 1);
         chk("rd_n", rd_n, sb[0].n);
         chk("rd_result", rd_result, sb[0].r);
         chk("rd_ovf", rd_ovf, sb[0].ovf);
      end else begin
         chk("rd_valid_empty", rd_valid, 0);
         chk("rd_result_empty", rd_result, 0);
         chk("rd_n_empty", rd_n, 0);
      end
      acc_push = v && sb.size() < 4;
      acc_pop  = re && sb.size() > 0;
      if (re && sb.size() == 0) m_under = 1;
      e.ovf = ovf | (n > 5'd12);
      e.n   = n;
      e.r   = r;
      if (acc_push && n <= 5'd12 && r != fact(int'(n))) m_mis = 1;
      @(posedge clk);
      if (acc_pop) void'(sb.pop_front());
      if (acc_push) sb.push_back(e);
      #1;
      chk("count", count, sb.size());
      chk("full", full, 64'(sb.size() == 4));
      chk("empty", empty, 64'(sb.size() == 0));
      chk("underflow", underflow, m_under);
`ifdef FACT_CHECK_EN
      chk("mismatch", mismatch, m_mis);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b1; in_n = 5'd9; in_result = 32'd362880; rd_en = 1'b0;
      #1;
      chk("rst_in_ready_pre", in_ready, 0);
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_result", rd_result, 0);
      chk("rst_empty", empty, 1);
      chk("rst_underflow", underflow, 0);
      sb.delete();
      m_under = 0;
      m_mis   = 0;
`ifdef FACT_CHECK_EN
      chk("rst_mismatch", mismatch, 0);
`endif
      rst = 1'b1; in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
   endtask

   initial begin
      rst = 1'b0; in_valid = 0; in_n = 0; in_result = 0; in_ovf = 0; rd_en = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_count", count, 0);
      chk("init_empty", empty, 1);
      chk("init_full", full, 0);
      chk("init_rd_valid", rd_valid, 0);
      chk("init_in_ready", in_ready, 0);
      chk("init_underflow", underflow, 0);
      rst = 1'b1;

      // single result, visible one cycle after push
      step(1, 5'd5, 32'd120, 0, 0);
      step(0, 5'd0, 32'd0, 0, 1);

      // fill to full, blocked push, pop while full, drain
      for (int k = 0; k < 4; k++) step(1, 5'(k), fact(k), 0, 0);
      step(1, 5'd4, 32'd24, 0, 0);
      step(1, 5'd4, 32'd24, 0, 1);
      for (int k = 0; k < 3; k++) step(0, 5'd0, 32'd0, 0, 1);
      step(0, 5'd0, 32'd0, 0, 0);

      // overflow tagging
      step(1, 5'd13, 32'h17328CC0, 0, 0);
      step(1, 5'd10, 32'd3628800, 1, 0);
      step(1, 5'd31, 32'd7, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 5'd0, 32'd0, 0, 1);

      // steady push+pop across pointer wrap
      step(1, 5'd1, 32'd1, 0, 0);
      step(1, 5'd2, 32'd2, 0, 0);
      for (int k = 3; k < 9; k++) step(1, 5'(k), fact(k), 0, 1);
      step(0, 5'd0, 32'd0, 0, 1);
      step(0, 5'd0, 32'd0, 0, 1);

      // underflow, sticky, and push with ignored pop on empty
      step(0, 5'd0, 32'd0, 0, 1);
      step(0, 5'd0, 32'd0, 0, 0);
      step(1, 5'd11, 32'd39916800, 0, 1);
      step(0, 5'd0, 32'd0, 0, 1);

      // reset mid-operation with 3 entries
      for (int k = 2; k < 5; k++) step(1, 5'(k), fact(k), 0, 0);
      do_reset();
      step(1, 5'd12, 32'd479001600, 0, 0);
      step(0, 5'd0, 32'd0, 0, 1);

`ifdef FACT_CHECK_EN
      step(1, 5'd6, 32'd720, 0, 0);
      step(1, 5'd7, 32'd5000, 0, 0);
      step(0, 5'd0, 32'd0, 0, 1);
      step(0, 5'd0, 32'd0, 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
